seq_window_monitor: RTL and testbench
=====================================

# seq_window_monitor

Synthesizable, parametrised multi-channel temporal sequence monitor for `start ##[MIN:MAX] stop` patterns. It is the RTL successor to the testbench-only `sequence … .triggered` checks. Each of `N_CH` independent channels watches a start/stop signal pair and reports a one-cycle `triggered` pulse when the stop arrives inside a runtime-programmable cycle window, or a `timeout` pulse when it does not. It sits beside the datapath as an on-chip protocol/latency checker with saturating hit counters readable by software.

## Interface
- `N_CH`, 2: number of independent channels.
- `CNT_W`, 4: width of the per-channel `min_dly`/`max_dly` fields (window up to 2^CNT_W−1 cycles).
- `HIT_W`, 8: width of the per-channel saturating hit counter.
- `RETRIG`, 0: 0 = a start seen while waiting is ignored; 1 = a start seen while waiting restarts the window.

Ports (clock and reset first):
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `en` in N_CH: per-channel enable. Deasserting it forces the channel to IDLE next edge.
- `start_i` in N_CH: sequence start event, sampled on posedge.
- `stop_i` in N_CH: sequence completion event, sampled on posedge.
- `min_dly` in N_CH×CNT_W: per-channel window lower bound; 0 is treated as 1.
- `max_dly` in N_CH×CNT_W: per-channel window upper bound.
- `clr_cnt` in N_CH: synchronous clear of the hit counter.
- `triggered_o` out N_CH: one-cycle pulse on a successful match.
- `timeout_o` out N_CH: one-cycle pulse when the window expires.
- `any_triggered_o` out 1: OR of `triggered_o`, registered with it (same cycle).
- `hit_cnt_o` out N_CH×HIT_W: saturating count of matches.

## Operation
- Per-channel FSM states: IDLE and WAIT. Internal elapsed counter `k` is CNT_W+1 bits wide.
- IDLE: on `en && start_i`, go to WAIT with k=1 on the next edge. `stop_i` is ignored in IDLE.
- WAIT, evaluated each edge with the current k:
  - If `stop_i && k ≥ min && k ≤ max`: match. Pulse `triggered_o`, increment `hit_cnt` (saturates at 2^HIT_W−1), go to IDLE.
  - Else if `k ≥ max`: pulse `timeout_o`, go to IDLE.
  - Else: k ← k+1.
  - A stop with k < min is ignored, as in SVA `##[m:n]`; the channel keeps waiting.
- Simultaneous start and match/timeout in the same cycle: the channel completes the current window and enters WAIT with k=1 (back-to-back sequences are not lost).
- Start while in WAIT with no match or timeout:
  - RETRIG=0: the start is ignored.
  - RETRIG=1: k ← 1; no timeout is reported for the abandoned window.
- `max < min` (after the min=0→1 fix-up): a match is impossible; the channel times out when k = max. `max = 0`: timeout at k=1.
- `min_dly` and `max_dly` are sampled live each cycle. Software changes them only while `en` is low.
- `clr_cnt` together with a match in the same cycle: the counter ends at 1.
- Channels are fully independent; there is no shared arbitration.

## Timing
- Reset values: all outputs 0, all FSMs IDLE, all k = 0, all hit counters 0.
- Start sampled at edge T0, stop sampled at edge T0+k (min ≤ k ≤ max): `triggered_o` is high during cycle T0+k to T0+k+1, i.e. registered one edge after the stop sample. `hit_cnt_o` updates on the same edge.
- Timeout: `timeout_o` is high for the cycle following edge T0+max.
- `triggered_o` and `timeout_o` are never both high on the same channel.
- `rst` or `en` low mid-window aborts the window silently: no pulse, k=0.

## Structure
- Package `seq_mon_pkg`: `seq_state_e` enum (IDLE, WAIT) and a `sat_inc` function for the saturating counter.
- Sub-module `seq_window_chan`: one channel (FSM, k counter, hit counter), parametrised by CNT_W, HIT_W and RETRIG.
- Top level: a generate loop over N_CH instances plus the `any_triggered_o` OR.

## Test plan
- N_CH=2, ch0 min=2 max=5: start at cycle 10, stop at cycle 13 → `triggered_o[0]` high in cycle 13→14, `hit_cnt[0]`=1, no timeout.
- ch0 min=2 max=5: stop at k=1 then none → stop ignored; `timeout_o[0]` high in the cycle after k=5; no trigger.
- RETRIG=0 vs RETRIG=1, ch0 min=1 max=3: start at k=0, second start at k=2, stop 3 cycles after the first start → RETRIG=0 triggers; RETRIG=1 triggers, since k=1 after restart is within [1,3].
- Back-to-back: stop and start in the same cycle, second stop 2 cycles later (min=max=2) → two `triggered_o` pulses, `hit_cnt`=2.
- HIT_W=2: five matches → `hit_cnt` saturates at 3; `clr_cnt` → 0.
- `rst` asserted at k=3 of an active window → all outputs 0 on the next cycle; a later stop produces no pulse.

Source files
------------

// File: rtl/seq_mon_pkg.sv
// Shared types and helpers for the start ##[MIN:MAX] stop sequence monitor.
package seq_mon_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } seq_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/seq_window_chan.sv
// One monitor channel: IDLE/WAIT FSM, elapsed-cycle counter and saturating hit counter.
module seq_window_chan
  import seq_mon_pkg::*;
#(
  parameter int CNT_W  = 4,
  parameter int HIT_W  = 8,
  parameter int RETRIG = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [CNT_W-1:0] min_dly,
  input  logic [CNT_W-1:0] max_dly,
  input  logic             clr_cnt,
  output logic             triggered_o,
  output logic             timeout_o,
  output logic [HIT_W-1:0] hit_cnt_o
);

  localparam logic [31:0] HIT_MAX   = 32'((64'd1 << HIT_W) - 64'd1);
  localparam logic [CNT_W:0] K_ONE  = {{CNT_W{1'b0}}, 1'b1};
  localparam bit          RETRIG_EN = (RETRIG != 0);

  seq_state_e       state_q, state_d;
  logic [CNT_W:0]   k_q, k_d;
  logic [CNT_W:0]   min_eff, max_ext;
  logic             trig_q, trig_d;
  logic             tmo_q, tmo_d;
  logic [HIT_W-1:0] hit_q, hit_d;
  logic             match, expire;

  always_comb begin
    min_eff = {1'b0, min_dly};
    if (min_dly == '0) min_eff = K_ONE;
    max_ext = {1'b0, max_dly};

    match  = en && (state_q == WAIT) && stop_i && (k_q >= min_eff) && (k_q <= max_ext);
    expire = en && (state_q == WAIT) && !match && (k_q >= max_ext);

    state_d = state_q;
    k_d     = k_q;
    trig_d  = 1'b0;
    tmo_d   = 1'b0;

    if (!en) begin
      state_d = IDLE;
      k_d     = '0;
    end else if (state_q == IDLE) begin
      if (start_i) begin
        state_d = WAIT;
        k_d     = K_ONE;
      end
    end else if (match || expire) begin
      // A start coinciding with the end of a window opens the next one immediately.
      trig_d  = match;
      tmo_d   = expire;
      state_d = start_i ? WAIT : IDLE;
      k_d     = start_i ? K_ONE : '0;
    end else if (start_i && RETRIG_EN) begin
      k_d = K_ONE;
    end else begin
      k_d = k_q + K_ONE;
    end

    hit_d = hit_q;
    if (clr_cnt) begin
      hit_d = match ? HIT_W'(1) : '0;
    end else if (match) begin
      hit_d = HIT_W'(sat_inc(32'(hit_q), HIT_MAX));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      trig_q  <= 1'b0;
      tmo_q   <= 1'b0;
      hit_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      trig_q  <= trig_d;
      tmo_q   <= tmo_d;
      hit_q   <= hit_d;
    end
  end

  assign triggered_o = trig_q;
  assign timeout_o   = tmo_q;
  assign hit_cnt_o   = hit_q;

endmodule

// File: rtl/seq_window_monitor.sv
// Multi-channel start ##[MIN:MAX] stop monitor: independent channels plus a combined trigger flag.
module seq_window_monitor #(
  parameter int N_CH   = 2,
  parameter int CNT_W  = 4,
  parameter int HIT_W  = 8,
  parameter int RETRIG = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_CH-1:0]             en,
  input  logic [N_CH-1:0]             start_i,
  input  logic [N_CH-1:0]             stop_i,
  input  logic [N_CH-1:0][CNT_W-1:0]  min_dly,
  input  logic [N_CH-1:0][CNT_W-1:0]  max_dly,
  input  logic [N_CH-1:0]             clr_cnt,
  output logic [N_CH-1:0]             triggered_o,
  output logic [N_CH-1:0]             timeout_o,
  output logic                        any_triggered_o,
  output logic [N_CH-1:0][HIT_W-1:0]  hit_cnt_o
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    seq_window_chan #(
      .CNT_W (CNT_W),
      .HIT_W (HIT_W),
      .RETRIG(RETRIG)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .en         (en[g]),
      .start_i    (start_i[g]),
      .stop_i     (stop_i[g]),
      .min_dly    (min_dly[g]),
      .max_dly    (max_dly[g]),
      .clr_cnt    (clr_cnt[g]),
      .triggered_o(triggered_o[g]),
      .timeout_o  (timeout_o[g]),
      .hit_cnt_o  (hit_cnt_o[g])
    );
  end

  // Both inputs of the OR are flops, so this flag lines up with triggered_o.
  assign any_triggered_o = |triggered_o;

endmodule

// File: tb/tb_seq_window_monitor.sv
// Bench: dut0 (HIT_W=2, RETRIG=0) and dut1 (HIT_W=8, RETRIG=1) share stimulus; a timestamp-based model predicts both.
module tb_seq_window_monitor;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] en, start_i, stop_i, clr_cnt;
  logic [1:0][3:0] min_dly, max_dly;

  logic [1:0] trig0, tmo0, trig1, tmo1;
  logic any0, any1;
  logic [1:0][1:0] hit0;
  logic [1:0][7:0] hit1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  bit active[2][2];
  int t0[2][2];
  int hits[2][2];
  bit et[2][2];
  bit eo[2][2];

  always #5 clk = ~clk;

  seq_window_monitor #(.N_CH(2), .CNT_W(4), .HIT_W(2), .RETRIG(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .start_i(start_i), .stop_i(stop_i),
    .min_dly(min_dly), .max_dly(max_dly), .clr_cnt(clr_cnt),
    .triggered_o(trig0), .timeout_o(tmo0), .any_triggered_o(any0), .hit_cnt_o(hit0)
  );

  seq_window_monitor #(.N_CH(2), .CNT_W(4), .HIT_W(8), .RETRIG(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .start_i(start_i), .stop_i(stop_i),
    .min_dly(min_dly), .max_dly(max_dly), .clr_cnt(clr_cnt),
    .triggered_o(trig1), .timeout_o(tmo1), .any_triggered_o(any1), .hit_cnt_o(hit1)
  );

  logic [8:0]  obs0;
  logic [20:0] obs1;
  assign obs0 = {trig0, tmo0, any0, hit0};
  assign obs1 = {trig1, tmo1, any1, hit1};

  function automatic logic [8:0] exp0();
    return {et[0][1], et[0][0], eo[0][1], eo[0][0], et[0][1] | et[0][0],
            2'(hits[0][1]), 2'(hits[0][0])};
  endfunction

  function automatic logic [20:0] exp1();
    return {et[1][1], et[1][0], eo[1][1], eo[1][0], et[1][1] | et[1][0],
            8'(hits[1][1]), 8'(hits[1][0])};
  endfunction

  // Model: a window is the time since its start edge; outcome follows the window rules directly.
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        int lo, hi, el, hmax;
        hmax = (d == 0) ? 3 : 255;
        et[d][c] = 1'b0;
        eo[d][c] = 1'b0;
        if (rst) begin
          active[d][c] = 1'b0;
          hits[d][c] = 0;
          continue;
        end
        lo = (min_dly[c] == 4'd0) ? 1 : int'(min_dly[c]);
        hi = int'(max_dly[c]);
        if (!en[c]) begin
          active[d][c] = 1'b0;
        end else if (active[d][c]) begin
          el = cyc - t0[d][c];
          if (stop_i[c] && el >= lo && el <= hi) et[d][c] = 1'b1;
          else if (el >= hi) eo[d][c] = 1'b1;
          if (et[d][c] || eo[d][c]) begin
            active[d][c] = start_i[c];
            t0[d][c] = cyc;
          end else if (start_i[c] && d == 1) begin
            t0[d][c] = cyc;
          end
        end else if (start_i[c]) begin
          active[d][c] = 1'b1;
          t0[d][c] = cyc;
        end
        if (clr_cnt[c]) hits[d][c] = et[d][c] ? 1 : 0;
        else if (et[d][c] && hits[d][c] < hmax) hits[d][c]++;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic program_win(input int mn0, input int mx0, input int mn1, input int mx1);
    en = 2'b00; start_i = 2'b00; stop_i = 2'b00; clr_cnt = 2'b00;
    tick();
    min_dly[0] = 4'(mn0); max_dly[0] = 4'(mx0);
    min_dly[1] = 4'(mn1); max_dly[1] = 4'(mx1);
    en = 2'b11;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 2'b11; start_i = 2'b11; stop_i = 2'b11; clr_cnt = 2'b00;
    min_dly = '0; max_dly = '0;
    tick();
    tick();
    checks += 2;
    if (obs0 !== 9'd0) begin failures++; $display("FAIL reset dut0 got=%b want=%b", obs0, 9'd0); end
    if (obs1 !== 21'd0) begin failures++; $display("FAIL reset dut1 got=%b want=%b", obs1, 21'd0); end
    rst = 1'b0;
  endtask

  task automatic test_match();
    bit st[6] = '{1, 0, 0, 0, 0, 0};
    bit sp[6] = '{0, 0, 0, 1, 0, 0};
    program_win(2, 5, 1, 4);
    for (int i = 0; i < 6; i++) begin
      start_i = {1'($urandom), st[i]};
      stop_i  = {1'($urandom), sp[i]};
      tick();
      checks += 3;
      if (obs0 !== exp0()) begin failures++; $display("FAIL match dut0 cyc=%0d got=%b want=%b", cyc, obs0, exp0()); end
      if (obs1 !== exp1()) begin failures++; $display("FAIL match dut1 cyc=%0d got=%b want=%b", cyc, obs1, exp1()); end
      if (trig0[0] !== (i == 3)) begin failures++; $display("FAIL match_pulse cyc=%0d got=%b want=%b", cyc, trig0[0], (i == 3)); end
    end
  endtask

  task automatic test_early_stop_timeout();
    bit st[8] = '{1, 0, 0, 0, 0, 0, 0, 0};
    bit sp[8] = '{0, 1, 0, 0, 0, 0, 0, 0};
    program_win(2, 5, 0, 3);
    for (int i = 0; i < 8; i++) begin
      start_i = {1'($urandom), st[i]};
      stop_i  = {1'($urandom), sp[i]};
      tick();
      checks += 4;
      if (obs0 !== exp0()) begin failures++; $display("FAIL early_stop dut0 cyc=%0d got=%b want=%b", cyc, obs0, exp0()); end
      if (obs1 !== exp1()) begin failures++; $display("FAIL early_stop dut1 cyc=%0d got=%b want=%b", cyc, obs1, exp1()); end
      if (tmo0[0] !== (i == 5)) begin failures++; $display("FAIL timeout_pulse cyc=%0d got=%b want=%b", cyc, tmo0[0], (i == 5)); end
      if (trig0[0] !== 1'b0) begin failures++; $display("FAIL early_no_trig cyc=%0d got=%b want=0", cyc, trig0[0]); end
    end
  endtask

  task automatic test_retrig();
    bit st[5] = '{1, 0, 1, 0, 0};
    bit sp[5] = '{0, 0, 0, 1, 0};
    program_win(1, 3, 2, 2);
    for (int i = 0; i < 5; i++) begin
      start_i = {1'($urandom), st[i]};
      stop_i  = {1'($urandom), sp[i]};
      tick();
      checks += 4;
      if (obs0 !== exp0()) begin failures++; $display("FAIL retrig dut0 cyc=%0d got=%b want=%b", cyc, obs0, exp0()); end
      if (obs1 !== exp1()) begin failures++; $display("FAIL retrig dut1 cyc=%0d got=%b want=%b", cyc, obs1, exp1()); end
      if (trig0[0] !== (i == 3)) begin failures++; $display("FAIL retrig0_pulse cyc=%0d got=%b want=%b", cyc, trig0[0], (i == 3)); end
      if (trig1[0] !== (i == 3)) begin failures++; $display("FAIL retrig1_pulse cyc=%0d got=%b want=%b", cyc, trig1[0], (i == 3)); end
    end
  endtask

  task automatic test_back_to_back();
    bit st[6] = '{1, 0, 1, 0, 0, 0};
    bit sp[6] = '{0, 0, 1, 0, 1, 0};
    program_win(2, 2, 0, 0);
    for (int i = 0; i < 6; i++) begin
      start_i = {1'($urandom), st[i]};
      stop_i  = {1'($urandom), sp[i]};
      tick();
      checks += 3;
      if (obs0 !== exp0()) begin failures++; $display("FAIL b2b dut0 cyc=%0d got=%b want=%b", cyc, obs0, exp0()); end
      if (obs1 !== exp1()) begin failures++; $display("FAIL b2b dut1 cyc=%0d got=%b want=%b", cyc, obs1, exp1()); end
      if (trig1[0] !== (i == 2 || i == 4)) begin failures++; $display("FAIL b2b_pulse cyc=%0d got=%b want=%b", cyc, trig1[0], (i == 2 || i == 4)); end
    end
  endtask

  task automatic test_saturate_clear();
    bit st[7] = '{1, 1, 1, 1, 1, 0, 0};
    bit sp[7] = '{0, 1, 1, 1, 1, 1, 0};
    program_win(1, 1, 3, 6);
    for (int i = 0; i < 7; i++) begin
      start_i = {1'($urandom), st[i]};
      stop_i  = {1'($urandom), sp[i]};
      clr_cnt = {1'b0, (i == 0)};
      tick();
      checks += 2;
      if (obs0 !== exp0()) begin failures++; $display("FAIL saturate dut0 cyc=%0d got=%b want=%b", cyc, obs0, exp0()); end
      if (obs1 !== exp1()) begin failures++; $display("FAIL saturate dut1 cyc=%0d got=%b want=%b", cyc, obs1, exp1()); end
    end
    checks++;
    if (hit0[0] !== 2'd3) begin failures++; $display("FAIL sat_value got=%0d want=3", hit0[0]); end
    start_i = 2'b01; stop_i = 2'b00; clr_cnt = 2'b01;
    tick();
    checks++;
    if (hit0[0] !== 2'd0) begin failures++; $display("FAIL clr_value got=%0d want=0", hit0[0]); end
    start_i = 2'b00; stop_i = 2'b01; clr_cnt = 2'b01;
    tick();
    checks += 3;
    if (hit0[0] !== 2'd1) begin failures++; $display("FAIL clr_with_match got=%0d want=1", hit0[0]); end
    if (obs0 !== exp0()) begin failures++; $display("FAIL clr_match dut0 got=%b want=%b", obs0, exp0()); end
    if (obs1 !== exp1()) begin failures++; $display("FAIL clr_match dut1 got=%b want=%b", obs1, exp1()); end
    clr_cnt = 2'b00; stop_i = 2'b00;
  endtask

  task automatic test_reset_mid_window();
    bit st[6] = '{1, 0, 0, 0, 0, 0};
    bit sp[6] = '{0, 0, 0, 0, 1, 1};
    program_win(2, 8, 1, 8);
    for (int i = 0; i < 6; i++) begin
      start_i = {1'($urandom), st[i]};
      stop_i  = {1'($urandom), sp[i]};
      rst = (i == 3);
      tick();
      checks += 3;
      if (obs0 !== exp0()) begin failures++; $display("FAIL rst_mid dut0 cyc=%0d got=%b want=%b", cyc, obs0, exp0()); end
      if (obs1 !== exp1()) begin failures++; $display("FAIL rst_mid dut1 cyc=%0d got=%b want=%b", cyc, obs1, exp1()); end
      if (i >= 3 && trig0[0] !== 1'b0) begin failures++; $display("FAIL rst_no_pulse cyc=%0d got=%b want=0", cyc, trig0[0]); end
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) begin
        program_win($urandom_range(0, 6), $urandom_range(0, 7), $urandom_range(0, 6), $urandom_range(0, 7));
      end
      en      = {($urandom % 12) != 0, ($urandom % 12) != 0};
      start_i = {($urandom % 4) == 0, ($urandom % 4) == 0};
      stop_i  = {($urandom % 3) == 0, ($urandom % 3) == 0};
      clr_cnt = {($urandom % 25) == 0, ($urandom % 25) == 0};
      rst     = ($urandom % 150) == 0;
      tick();
      checks += 2;
      if (obs0 !== exp0()) begin failures++; $display("FAIL random dut0 cyc=%0d got=%b want=%b", cyc, obs0, exp0()); end
      if (obs1 !== exp1()) begin failures++; $display("FAIL random dut1 cyc=%0d got=%b want=%b", cyc, obs1, exp1()); end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_match();
    test_early_stop_timeout();
    test_retrig();
    test_back_to_back();
    test_saturate_clear();
    test_reset_mid_window();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
